// File: rtl/usr_pkg.sv
// Shared encodings for the counted universal shift register: per-step op codes
// and the two-state run FSM.
package usr_pkg;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_SHL_UP = 3'b001;
  localparam logic [2:0] OP_SHR_DN = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_INV    = 3'b100;
  localparam logic [2:0] OP_ROT_UP = 3'b101;
  localparam logic [2:0] OP_ROT_DN = 3'b110;
  localparam logic [2:0] OP_ASR    = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_reg_n_if.sv
// Control/data bundle between the datapath controller (master) and the
// shift register (slave).
interface universal_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
);
  logic [2:0]       S;
  logic [WIDTH-1:0] I;
  logic             sin_lo;
  logic             sin_hi;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] O;
  logic             busy;
  logic             done;

  modport master (output S, I, sin_lo, sin_hi, start, amt, input O, busy, done);
  modport slave  (input S, I, sin_lo, sin_hi, start, amt, output O, busy, done);
endinterface

// File: rtl/usr_step.sv
// One step of the selected op, purely combinational; shared by legacy and
// counted modes.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] o_i,
  input  logic [WIDTH-1:0] i_i,
  input  logic             sin_lo_i,
  input  logic             sin_hi_i,
  output logic [WIDTH-1:0] o_nxt_o
);

  always_comb begin
    o_nxt_o = o_i;
    case (op_i)
      OP_HOLD:   o_nxt_o = o_i;
      OP_SHL_UP: o_nxt_o = {o_i[WIDTH-2:0], sin_lo_i};
      OP_SHR_DN: o_nxt_o = {sin_hi_i, o_i[WIDTH-1:1]};
      OP_LOAD:   o_nxt_o = i_i;
      OP_INV:    o_nxt_o = ~o_i;
      OP_ROT_UP: o_nxt_o = {o_i[WIDTH-2:0], o_i[WIDTH-1]};
      OP_ROT_DN: o_nxt_o = {o_i[0], o_i[WIDTH-1:1]};
      OP_ASR:    o_nxt_o = {o_i[WIDTH-1], o_i[WIDTH-1:1]};
      default:   o_nxt_o = o_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register: one step per cycle in legacy mode, or a
// counted run of amt steps launched by start with busy/done handshake.
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  clear,
  universal_shift_reg_n_if.slave bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             done_q, done_d;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_nxt;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (step_op),
    .o_i      (o_q),
    .i_i      (bus.I),
    .sin_lo_i (bus.sin_lo),
    .sin_hi_i (bus.sin_hi),
    .o_nxt_o  (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    o_d     = o_q;
    done_d  = 1'b0;
    step_op = bus.S;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // accept edge: O holds, op and count are captured
          op_d  = bus.S;
          cnt_d = bus.amt;
          if (bus.amt != '0) state_d = ST_RUN;
          else               done_d  = 1'b1;
        end else begin
          o_d = step_nxt;
        end
      end
      ST_RUN: begin
        step_op = op_q;
        o_d     = step_nxt;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n: directed sequences with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_universal_shift_reg_n;
  localparam int W  = 8;
  localparam int AW = $clog2(W + 1);

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  universal_shift_reg_n_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  universal_shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one step expressed as plain arithmetic on the register value
  function automatic logic [W-1:0] mstep(input logic [2:0] op, input logic [W-1:0] o,
                                         input logic [W-1:0] ii, input logic lo, input logic hi);
    logic signed [W-1:0] s;
    logic [W-1:0] msb;
    msb = '0;
    msb[W-1] = 1'b1;
    s = o;
    case (op)
      3'd0: return o;
      3'd1: return (o << 1) | W'(lo);
      3'd2: return (o >> 1) | (hi ? msb : '0);
      3'd3: return ii;
      3'd4: return ~o;
      3'd5: return (o << 1) | (o >> (W - 1));
      3'd6: return (o >> 1) | ((o & W'(1)) != 0 ? msb : '0);
      default: return W'(s >>> 1);
    endcase
  endfunction

  logic [W-1:0] m_o;
  logic         m_busy, m_done, m_ok;
  logic [2:0]   m_op;
  int           m_rem;
  initial m_ok = 1'b0;

  always @(posedge clk) begin
    if (clear) begin
      m_o = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_op = 3'd0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (bus.start) begin
          m_op   = bus.S;
          m_rem  = int'(bus.amt);
          m_busy = (m_rem != 0);
          m_done = (m_rem == 0);
        end else begin
          m_o    = mstep(bus.S, m_o, bus.I, bus.sin_lo, bus.sin_hi);
          m_done = 1'b0;
        end
      end else begin
        m_o    = mstep(m_op, m_o, bus.I, bus.sin_lo, bus.sin_hi);
        m_rem  = m_rem - 1;
        m_busy = (m_rem != 0);
        m_done = (m_rem == 0);
      end
    end
    #1;
    if (m_ok) begin
      chk("model_O", bus.O, m_o);
      chk("model_busy", bus.busy, m_busy);
      chk("model_done", bus.done, m_done);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.start = 1'b0; bus.S = 3'b011; bus.I = v;
    cyc();
    bus.S = 3'b000;
  endtask

  initial begin
    clear = 1'b1;
    bus.start = 1'b1; bus.S = 3'b011; bus.I = 8'hFF;
    bus.sin_lo = 1'b0; bus.sin_hi = 1'b0; bus.amt = '0;
    cyc(2);
    chk("reset_O", bus.O, 8'h00);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);

    // legacy mode
    clear = 1'b0; bus.start = 1'b0; bus.S = 3'b011; bus.I = 8'hA5;
    cyc();
    chk("legacy_load", bus.O, 8'hA5);
    bus.S = 3'b100; cyc();
    chk("legacy_inv", bus.O, 8'h5A);
    bus.S = 3'b000; cyc();
    chk("legacy_hold", bus.O, 8'h5A);

    // counted rotate up
    load(8'h81);
    bus.start = 1'b1; bus.S = 3'b101; bus.amt = AW'(3);
    cyc();
    chk("rot_accept_O", bus.O, 8'h81);
    chk("rot_accept_busy", bus.busy, 1'b1);
    bus.start = 1'b0; bus.S = 3'b000;
    cyc(); chk("rot_1", bus.O, 8'h03); chk("rot_1_busy", bus.busy, 1'b1);
    cyc(); chk("rot_2", bus.O, 8'h06); chk("rot_2_busy", bus.busy, 1'b1);
    cyc(); chk("rot_3", bus.O, 8'h0C);
    chk("rot_done", bus.done, 1'b1); chk("rot_end_busy", bus.busy, 1'b0);
    cyc(); chk("rot_done_low", bus.done, 1'b0);

    // counted arithmetic shift down
    load(8'h90);
    bus.start = 1'b1; bus.S = 3'b111; bus.amt = AW'(2);
    cyc(); bus.start = 1'b0; bus.S = 3'b000;
    cyc(); chk("asr_1", bus.O, 8'hC8);
    cyc(); chk("asr_2", bus.O, 8'hE4); chk("asr_done", bus.done, 1'b1);

    // counted serial shift up
    load(8'h00);
    bus.start = 1'b1; bus.S = 3'b001; bus.sin_lo = 1'b1; bus.amt = AW'(4);
    cyc(); bus.start = 1'b0; bus.S = 3'b000;
    cyc(4); chk("shl_4", bus.O, 8'h0F); chk("shl_done", bus.done, 1'b1);
    bus.sin_lo = 1'b0;

    // zero-length run
    load(8'h3C);
    bus.start = 1'b1; bus.S = 3'b100; bus.amt = '0;
    cyc(); bus.start = 1'b0; bus.S = 3'b000;
    chk("amt0_done", bus.done, 1'b1); chk("amt0_busy", bus.busy, 1'b0);
    chk("amt0_O", bus.O, 8'h3C);
    cyc(); chk("amt0_done_low", bus.done, 1'b0);

    // mid-run: ignored controls, then abort by clear
    load(8'hA5);
    bus.start = 1'b1; bus.S = 3'b010; bus.sin_hi = 1'b0; bus.amt = AW'(5);
    cyc();
    bus.S = 3'b011; bus.I = 8'hFF; bus.amt = '0;
    cyc(); chk("mid_1", bus.O, 8'h52); chk("mid_busy", bus.busy, 1'b1);
    clear = 1'b1;
    cyc(); chk("abort_O", bus.O, 8'h00); chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    clear = 1'b0; bus.start = 1'b0; bus.S = 3'b000;
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("abort_no_done", bus.done, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clear      = ($urandom_range(0, 63) == 0);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.S      = 3'($urandom_range(0, 7));
      bus.I      = W'($urandom);
      bus.sin_lo = 1'($urandom);
      bus.sin_hi = 1'($urandom);
      bus.amt    = AW'($urandom_range(0, (1 << AW) - 1));
      cyc();
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
